// File: rtl/reg_block.sv
// reg_block: CPU-facing control/status register block (CTRL, STATUS, IRQ, SCRATCH, ID).
// Define REG_BLOCK_ERR_RSP_EN to report unmapped accesses and read-only writes via rd_err/wr_err.
module reg_block #(
   parameter int          ADDR_WIDTH    = 5,
   parameter logic [31:0] ID_VALUE      = 32'h5244_4C01,
   parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpuif_req,
   input  logic                  cpuif_req_is_wr,
   input  logic [ADDR_WIDTH-1:0] cpuif_addr,
   input  logic [31:0]           cpuif_wr_data,
   input  logic [31:0]           cpuif_wr_biten,
   output logic                  cpuif_req_stall_wr,
   output logic                  cpuif_req_stall_rd,
   output logic                  cpuif_rd_ack,
   output logic                  cpuif_rd_err,
   output logic [31:0]           cpuif_rd_data,
   output logic                  cpuif_wr_ack,
   output logic                  cpuif_wr_err,
   input  logic [15:0]           hwif_in_status,
   input  logic [7:0]            hwif_in_irq_set,
   output logic                  hwif_out_ctrl_enable,
   output logic [3:0]            hwif_out_ctrl_mode,
   output logic [31:0]           hwif_out_scratch,
   output logic                  hwif_out_irq
);

   localparam int WW = ADDR_WIDTH - 2;

   logic [WW-1:0] word_addr;
   logic          rd_en;
   logic          wr_en;
   logic          sel_ctrl;
   logic          sel_status;
   logic          sel_irq_status;
   logic          sel_irq_mask;
   logic          sel_scratch;
   logic          sel_id;
   logic          mapped;
   logic [31:0]   rd_mux;
   logic [7:0]    irq_clear;
   logic          ctrl_enable;
   logic [3:0]    ctrl_mode;
   logic [7:0]    irq_status;
   logic [7:0]    irq_mask;
   logic [31:0]   scratch;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^cpuif_addr[1:0];
   assign word_addr        = cpuif_addr[ADDR_WIDTH-1:2];
   assign rd_en            = cpuif_req & ~cpuif_req_is_wr;
   assign wr_en            = cpuif_req & cpuif_req_is_wr;

   assign cpuif_req_stall_wr = 1'b0;
   assign cpuif_req_stall_rd = 1'b0;

   assign hwif_out_ctrl_enable = ctrl_enable;
   assign hwif_out_ctrl_mode   = ctrl_mode;
   assign hwif_out_scratch     = scratch;

   assign sel_ctrl       = (word_addr == WW'(0));
   assign sel_status     = (word_addr == WW'(1));
   assign sel_irq_status = (word_addr == WW'(2));
   assign sel_irq_mask   = (word_addr == WW'(3));
   assign sel_scratch    = (word_addr == WW'(4));
   assign sel_id         = (word_addr == WW'(5));
   assign mapped         = sel_ctrl | sel_status | sel_irq_status | sel_irq_mask | sel_scratch | sel_id;

   // Read mux returns zero for unmapped addresses
   always_comb begin
      rd_mux = 32'h0;
      if (sel_ctrl)       rd_mux = {24'h0, ctrl_mode, 3'b000, ctrl_enable};
      if (sel_status)     rd_mux = {16'h0, hwif_in_status};
      if (sel_irq_status) rd_mux = {24'h0, irq_status};
      if (sel_irq_mask)   rd_mux = {24'h0, irq_mask};
      if (sel_scratch)    rd_mux = scratch;
      if (sel_id)         rd_mux = ID_VALUE;
   end

   assign irq_clear = (wr_en && sel_irq_status) ? (cpuif_wr_data[7:0] & cpuif_wr_biten[7:0]) : 8'h00;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cpuif_rd_ack  <= 1'b0;
         cpuif_wr_ack  <= 1'b0;
         cpuif_rd_err  <= 1'b0;
         cpuif_wr_err  <= 1'b0;
         cpuif_rd_data <= 32'h0;
         ctrl_enable   <= 1'b0;
         ctrl_mode     <= 4'h0;
         irq_status    <= 8'h00;
         irq_mask      <= 8'h00;
         scratch       <= SCRATCH_RESET;
         hwif_out_irq  <= 1'b0;
      end else begin
         cpuif_rd_ack  <= rd_en;
         cpuif_wr_ack  <= wr_en;
         cpuif_rd_data <= rd_en ? rd_mux : 32'h0;
`ifdef REG_BLOCK_ERR_RSP_EN
         cpuif_rd_err  <= rd_en & ~mapped;
         cpuif_wr_err  <= wr_en & (~mapped | sel_status | sel_id);
`else
         cpuif_rd_err  <= 1'b0;
         cpuif_wr_err  <= 1'b0;
`endif
         if (wr_en && sel_ctrl) begin
            ctrl_enable <= (ctrl_enable & ~cpuif_wr_biten[0]) | (cpuif_wr_data[0] & cpuif_wr_biten[0]);
            ctrl_mode   <= (ctrl_mode & ~cpuif_wr_biten[7:4]) | (cpuif_wr_data[7:4] & cpuif_wr_biten[7:4]);
         end
         if (wr_en && sel_irq_mask)
            irq_mask <= (irq_mask & ~cpuif_wr_biten[7:0]) | (cpuif_wr_data[7:0] & cpuif_wr_biten[7:0]);
         if (wr_en && sel_scratch)
            scratch <= (scratch & ~cpuif_wr_biten) | (cpuif_wr_data & cpuif_wr_biten);
         // Hardware set is OR'd in after the clear so a coincident set wins
         irq_status   <= (irq_status & ~irq_clear) | hwif_in_irq_set;
         hwif_out_irq <= |(irq_status & irq_mask);
      end
   end

endmodule

// File: tb/tb_reg_block.sv
// tb_reg_block: directed-vector bench for reg_block with hand-computed expectations.
module tb_reg_block;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpuif_req;
   logic        cpuif_req_is_wr;
   logic [4:0]  cpuif_addr;
   logic [31:0] cpuif_wr_data;
   logic [31:0] cpuif_wr_biten;
   logic        cpuif_req_stall_wr;
   logic        cpuif_req_stall_rd;
   logic        cpuif_rd_ack;
   logic        cpuif_rd_err;
   logic [31:0] cpuif_rd_data;
   logic        cpuif_wr_ack;
   logic        cpuif_wr_err;
   logic [15:0] hwif_in_status;
   logic [7:0]  hwif_in_irq_set;
   logic        hwif_out_ctrl_enable;
   logic [3:0]  hwif_out_ctrl_mode;
   logic [31:0] hwif_out_scratch;
   logic        hwif_out_irq;

   int vectorCount = 0;
   int missCount   = 0;

`ifdef REG_BLOCK_ERR_RSP_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   reg_block dut (
      .clk                  (clk),
      .rst                  (rst),
      .cpuif_req            (cpuif_req),
      .cpuif_req_is_wr      (cpuif_req_is_wr),
      .cpuif_addr           (cpuif_addr),
      .cpuif_wr_data        (cpuif_wr_data),
      .cpuif_wr_biten       (cpuif_wr_biten),
      .cpuif_req_stall_wr   (cpuif_req_stall_wr),
      .cpuif_req_stall_rd   (cpuif_req_stall_rd),
      .cpuif_rd_ack         (cpuif_rd_ack),
      .cpuif_rd_err         (cpuif_rd_err),
      .cpuif_rd_data        (cpuif_rd_data),
      .cpuif_wr_ack         (cpuif_wr_ack),
      .cpuif_wr_err         (cpuif_wr_err),
      .hwif_in_status       (hwif_in_status),
      .hwif_in_irq_set      (hwif_in_irq_set),
      .hwif_out_ctrl_enable (hwif_out_ctrl_enable),
      .hwif_out_ctrl_mode   (hwif_out_ctrl_mode),
      .hwif_out_scratch     (hwif_out_scratch),
      .hwif_out_irq         (hwif_out_irq)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drive one request for a cycle; returns at the next falling edge with the response visible
   task automatic applyStimulus(input logic isWr, input logic [4:0] addr, input logic [31:0] data, input logic [31:0] biten);
      @(negedge clk);
      cpuif_req       = 1'b1;
      cpuif_req_is_wr = isWr;
      cpuif_addr      = addr;
      cpuif_wr_data   = data;
      cpuif_wr_biten  = biten;
      @(negedge clk);
      cpuif_req       = 1'b0;
      cpuif_req_is_wr = 1'b0;
   endtask

   task automatic readCheck(input string tag, input logic [4:0] addr, input logic [31:0] expected);
      applyStimulus(1'b0, addr, 32'h0, 32'h0);
      checkOutput({tag, "_ack"}, {31'h0, cpuif_rd_ack}, 32'h1);
      checkOutput({tag, "_wrack"}, {31'h0, cpuif_wr_ack}, 32'h0);
      checkOutput(tag, cpuif_rd_data, expected);
   endtask

   task automatic writeCheck(input string tag, input logic [4:0] addr, input logic [31:0] data, input logic [31:0] biten, input logic expErr);
      applyStimulus(1'b1, addr, data, biten);
      checkOutput({tag, "_ack"}, {31'h0, cpuif_wr_ack}, 32'h1);
      checkOutput({tag, "_rdack"}, {31'h0, cpuif_rd_ack}, 32'h0);
      checkOutput({tag, "_err"}, {31'h0, cpuif_wr_err}, {31'h0, expErr});
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst             = 1'b0;
      cpuif_req       = 1'b0;
      cpuif_req_is_wr = 1'b0;
      cpuif_addr      = 5'h0;
      cpuif_wr_data   = 32'h0;
      cpuif_wr_biten  = 32'h0;
      hwif_in_status  = 16'h0;
      hwif_in_irq_set = 8'h0;
      idle(3);

      checkOutput("rst_rd_ack", {31'h0, cpuif_rd_ack}, 32'h0);
      checkOutput("rst_wr_ack", {31'h0, cpuif_wr_ack}, 32'h0);
      checkOutput("rst_scratch", hwif_out_scratch, 32'h0);
      checkOutput("rst_ctrl", {27'h0, hwif_out_ctrl_mode, hwif_out_ctrl_enable}, 32'h0);
      checkOutput("rst_irq", {31'h0, hwif_out_irq}, 32'h0);
      checkOutput("rst_xfree", {31'h0, $isunknown({hwif_out_ctrl_enable, hwif_out_ctrl_mode, hwif_out_scratch, hwif_out_irq})}, 32'h0);
      checkOutput("stall", {30'h0, cpuif_req_stall_wr, cpuif_req_stall_rd}, 32'h0);
      rst = 1'b1;

      readCheck("rd_ctrl", 5'h00, 32'h0);
      readCheck("rd_irqst", 5'h08, 32'h0);
      readCheck("rd_mask", 5'h0C, 32'h0);
      readCheck("rd_scratch", 5'h10, 32'h0);
      readCheck("rd_id", 5'h14, 32'h5244_4C01);
      checkOutput("rd_id_err", {31'h0, cpuif_rd_err}, 32'h0);
      idle(1);
      checkOutput("ack_one_cycle", {31'h0, cpuif_rd_ack}, 32'h0);
      checkOutput("rd_data_idle", cpuif_rd_data, 32'h0);

      writeCheck("wr_scratch", 5'h10, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b0);
      checkOutput("hw_scratch", hwif_out_scratch, 32'hDEAD_0000);
      readCheck("rb_scratch", 5'h10, 32'hDEAD_0000);
      writeCheck("wr_scratch_lo", 5'h13, 32'h1234_5678, 32'h0000_00FF, 1'b0);
      checkOutput("hw_scratch_lo", hwif_out_scratch, 32'hDEAD_0078);

      writeCheck("wr_ctrl", 5'h00, 32'h0000_0035, 32'hFFFF_FFFF, 1'b0);
      checkOutput("ctrl_enable", {31'h0, hwif_out_ctrl_enable}, 32'h1);
      checkOutput("ctrl_mode", {28'h0, hwif_out_ctrl_mode}, 32'h3);
      readCheck("rb_ctrl", 5'h00, 32'h0000_0031);
      hwif_in_status = 16'hA5A5;
      readCheck("rd_status", 5'h04, 32'h0000_A5A5);

      // Back-to-back reads: response for the first shows while the second is issued
      @(negedge clk);
      cpuif_req = 1'b1; cpuif_req_is_wr = 1'b0; cpuif_addr = 5'h14;
      @(negedge clk);
      checkOutput("b2b_ack0", {31'h0, cpuif_rd_ack}, 32'h1);
      checkOutput("b2b_data0", cpuif_rd_data, 32'h5244_4C01);
      cpuif_addr = 5'h10;
      @(negedge clk);
      cpuif_req = 1'b0;
      checkOutput("b2b_ack1", {31'h0, cpuif_rd_ack}, 32'h1);
      checkOutput("b2b_data1", cpuif_rd_data, 32'hDEAD_0078);
      idle(1);
      checkOutput("b2b_done", {31'h0, cpuif_rd_ack}, 32'h0);

      writeCheck("wr_mask", 5'h0C, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0);
      hwif_in_irq_set = 8'h05;
      idle(1);
      hwif_in_irq_set = 8'h00;
      idle(1);
      checkOutput("irq_on", {31'h0, hwif_out_irq}, 32'h1);
      readCheck("rd_irqst_set", 5'h08, 32'h0000_0005);
      writeCheck("clr_irq", 5'h08, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0);
      idle(1);
      checkOutput("irq_off", {31'h0, hwif_out_irq}, 32'h0);
      readCheck("rd_irqst_clr", 5'h08, 32'h0000_0001);

      @(negedge clk);
      hwif_in_irq_set = 8'h04;
      cpuif_req = 1'b1; cpuif_req_is_wr = 1'b1; cpuif_addr = 5'h08;
      cpuif_wr_data = 32'h4; cpuif_wr_biten = 32'hFFFF_FFFF;
      @(negedge clk);
      cpuif_req = 1'b0; cpuif_req_is_wr = 1'b0; hwif_in_irq_set = 8'h00;
      idle(1);
      readCheck("set_wins", 5'h08, 32'h0000_0005);
      checkOutput("irq_set_wins", {31'h0, hwif_out_irq}, 32'h1);

      readCheck("rd_unmapped", 5'h18, 32'h0);
      checkOutput("rd_unmapped_err", {31'h0, cpuif_rd_err}, {31'h0, ERR_EXP});
      writeCheck("wr_id", 5'h14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ERR_EXP);
      writeCheck("wr_status", 5'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ERR_EXP);
      writeCheck("wr_unmapped", 5'h1C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ERR_EXP);
      readCheck("id_intact", 5'h14, 32'h5244_4C01);
      checkOutput("scratch_intact", hwif_out_scratch, 32'hDEAD_0078);

      // Request issued together with reset must be dropped
      @(negedge clk);
      rst = 1'b0;
      cpuif_req = 1'b1; cpuif_req_is_wr = 1'b1; cpuif_addr = 5'h10;
      cpuif_wr_data = 32'h1111_2222; cpuif_wr_biten = 32'hFFFF_FFFF;
      @(negedge clk);
      cpuif_req = 1'b0; cpuif_req_is_wr = 1'b0;
      checkOutput("drop_ack", {31'h0, cpuif_wr_ack}, 32'h0);
      checkOutput("rst_scratch2", hwif_out_scratch, 32'h0);
      checkOutput("rst_ctrl2", {27'h0, hwif_out_ctrl_mode, hwif_out_ctrl_enable}, 32'h0);
      checkOutput("rst_irq2", {31'h0, hwif_out_irq}, 32'h0);
      rst = 1'b1;
      readCheck("post_rst_irqst", 5'h08, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
